// File: rtl/ahb_lite_pkg.sv
// rtl/ahb_lite_pkg.sv - shared AHB-Lite types, register map and master command format
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [3:0] REG_STATUS    = 4'h0;
    localparam logic [3:0] REG_CTRL      = 4'h2;
    localparam logic [3:0] REG_SAMPLE    = 4'h4;
    localparam logic [3:0] REG_COEFF     = 4'h6;
    localparam logic [3:0] REG_RESULT    = 4'h8;
    localparam logic [3:0] REG_COEFFCONF = 4'hE;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_DATA = 3'd2,
        ST_DATA      = 3'd3,
        ST_ERR_IDLE  = 3'd4
    } master_state_t;

    typedef struct packed {
        logic        write;
        logic        size;
        logic [3:0]  addr;
        logic [15:0] wdata;
    } ahb_cmd_t;

    localparam int CMD_W = $bits(ahb_cmd_t);

endpackage

// File: rtl/ahb_cmd_fifo.sv
// rtl/ahb_cmd_fifo.sv - command queue with wrap-bit pointers for full/empty
module ahb_cmd_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // full blocks push even when a pop happens in the same cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ahb_lite_master.sv
// rtl/ahb_lite_master.sv - queued AHB-Lite initiator issuing pipelined single NONSEQ transfers
module ahb_lite_master
    import ahb_lite_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_size,
    input  logic [3:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        hsel,
    output logic [3:0]  haddr,
    output logic        hsize,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [15:0] hwdata,
    input  logic [15:0] hrdata,
    input  logic        hresp,
    input  logic        hready
);

    master_state_t state, state_next;
    ahb_cmd_t      fifo_din, fifo_head, a_cmd;
    logic          fifo_full, fifo_empty;
    logic          a_valid, d_valid, err_idle;
    logic          d_done, d_err, a_accept, a_load, a_next, d_next;
    logic          d_write, d_size;

    assign fifo_din = '{write: cmd_write, size: cmd_size, addr: cmd_addr, wdata: cmd_wdata};

    ahb_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (CMD_W)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (a_load),
        .din   (fifo_din),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // slot occupancy is encoded entirely in the state register
    assign a_valid  = (state == ST_ADDR) || (state == ST_ADDR_DATA) || (state == ST_ERR_IDLE);
    assign d_valid  = (state == ST_ADDR_DATA) || (state == ST_DATA);
    assign err_idle = (state == ST_ERR_IDLE);

    assign d_done   = d_valid && hready;
    assign d_err    = d_done && hresp;
    assign a_accept = a_valid && !err_idle && hready && !d_err;
    // an empty A slot may fill during a stall; a held A slot may not
    assign a_load   = !fifo_empty && (!a_valid || a_accept);
    assign a_next   = a_load || (a_valid && !a_accept);
    assign d_next   = a_accept || (d_valid && !d_done);

    always_comb begin
        state_next = ST_IDLE;
        if (d_err && a_valid)      state_next = ST_ERR_IDLE;
        else if (a_next && d_next) state_next = ST_ADDR_DATA;
        else if (a_next)           state_next = ST_ADDR;
        else if (d_next)           state_next = ST_DATA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            a_cmd     <= '0;
            d_write   <= 1'b0;
            d_size    <= 1'b0;
            hwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state <= state_next;
            if (a_load) a_cmd <= fifo_head;
            if (a_accept) begin
                d_write <= a_cmd.write;
                d_size  <= a_cmd.size;
                hwdata  <= a_cmd.wdata;
            end
            rsp_valid <= d_done;
            rsp_err   <= d_err;
            if (d_done && !hresp && !d_write)
                rsp_rdata <= d_size ? hrdata : {8'h00, hrdata[7:0]};
            else
                rsp_rdata <= '0;
        end
    end

    assign cmd_ready = !fifo_full;
    assign htrans    = (a_valid && !err_idle) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hsel      = a_valid && !err_idle;
    assign haddr     = a_cmd.addr;
    assign hsize     = a_cmd.size;
    assign hwrite    = a_cmd.write;
    assign busy      = !fifo_empty || a_valid || d_valid || rsp_valid;

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb/tb_ahb_lite_master.sv - directed scoreboard bench for ahb_lite_master with a register-file slave
module tb_ahb_lite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_size;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [15:0] rsp_rdata;
    logic        hsel, hsize, hwrite, hresp, hready;
    logic [3:0]  haddr;
    logic [1:0]  htrans;
    logic [15:0] hwdata, hrdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [16:0] sb_q [$];
    logic [16:0] exp_r;

    logic [1:0]  tr_log [0:1023];
    logic [3:0]  ad_log [0:1023];
    logic [15:0] wd_log [0:1023];
    logic        rv_log [0:1023];
    logic        sel_log [0:1023];
    logic        hw_log [0:1023];
    logic        hs_log [0:1023];

    logic [3:0]  fa [6] = '{4'h2, 4'h4, 4'h6, 4'h8, 4'h4, 4'h2};
    logic        fs [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] fe [5] = '{16'hA1B2, 16'h1111, 16'h0101, 16'hCAFE, 16'h0011};

    ahb_lite_master #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .hsel(hsel), .haddr(haddr), .hsize(hsize), .htrans(htrans), .hwrite(hwrite),
        .hwdata(hwdata), .hrdata(hrdata), .hresp(hresp), .hready(hready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // register-file slave; address 0 is read-only and errors on write
    logic [15:0] smem [0:7];
    logic        dp_valid, dp_write;
    logic [3:0]  dp_addr;
    assign hresp  = dp_valid && dp_write && (dp_addr == 4'h0);
    assign hrdata = (dp_valid && !dp_write) ? smem[dp_addr[3:1]] : 16'h0000;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_valid <= 1'b0;
        end else if (hready) begin
            if (dp_valid && dp_write && !hresp) smem[dp_addr[3:1]] <= hwdata;
            dp_valid <= hsel && (htrans == 2'b10) && !hresp;
            dp_addr  <= haddr;
            dp_write <= hwrite;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < 1024) begin
            tr_log[cyc]  = htrans;
            ad_log[cyc]  = haddr;
            wd_log[cyc]  = hwdata;
            rv_log[cyc]  = rsp_valid;
            sel_log[cyc] = hsel;
            hw_log[cyc]  = hwrite;
            hs_log[cyc]  = hsize;
        end
        if (!rst && rsp_valid) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL rsp_unexpected: got a response, expected none queued");
            end
            if (sb_q.size() != 0) begin
                exp_r = sb_q.pop_front();
                check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_r[16]});
                check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, exp_r[15:0]});
            end
        end
    end

    task automatic push_cmd(input logic w, input logic s, input logic [3:0] a,
                            input logic [15:0] d, input logic [16:0] exp, output int acc);
        cmd_write = w; cmd_size = s; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check("push_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        else sb_q.push_back(exp);
        @(posedge clk); #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_bus(input string tag, input int c, input logic [1:0] tr, input logic [3:0] ad);
        check({tag, "_htrans"}, {30'd0, tr_log[c]}, {30'd0, tr});
        if (tr == 2'b10) check({tag, "_haddr"}, {28'd0, ad_log[c]}, {28'd0, ad});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, n2, k;
        hready = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 1'b0;
        cmd_addr = 4'h0; cmd_wdata = 16'h0000;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("rst_htrans", {30'd0, htrans}, 32'd0);
        check("rst_hsel", {31'd0, hsel}, 32'd0);
        check("rst_hwrite", {31'd0, hwrite}, 32'd0);
        check("rst_hsize", {31'd0, hsize}, 32'd0);
        check("rst_haddr", {28'd0, haddr}, 32'd0);
        check("rst_hwdata", {16'd0, hwdata}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // reset in the middle of a three-command burst
        push_cmd(1'b1, 1'b1, 4'hA, 16'h1111, 17'h0, n0);
        push_cmd(1'b1, 1'b1, 4'hC, 16'h2222, 17'h0, n1);
        push_cmd(1'b1, 1'b1, 4'hE, 16'h3333, 17'h0, n2);
        cmd_valid = 1'b0;
        check("burst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("midrst_htrans", {30'd0, htrans}, 32'd0);
        check("midrst_hsel", {31'd0, hsel}, 32'd0);
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("postrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("postrst_busy", {31'd0, busy}, 32'd0);

        // single write latency
        push_cmd(1'b1, 1'b1, 4'h4, 16'hBEEF, 17'h0, n0);
        cmd_valid = 1'b0;
        wait_idle();
        check_bus("wr_n1", n0 + 1, 2'b00, 4'h0);
        check_bus("wr_n2", n0 + 2, 2'b10, 4'h4);
        check("wr_hsel", {31'd0, sel_log[n0 + 2]}, 32'd1);
        check("wr_hwrite", {31'd0, hw_log[n0 + 2]}, 32'd1);
        check("wr_hsize", {31'd0, hs_log[n0 + 2]}, 32'd1);
        check("wr_hwdata", {16'd0, wd_log[n0 + 3]}, 32'h0000BEEF);
        check("wr_rsp_n3", {31'd0, rv_log[n0 + 3]}, 32'd0);
        check("wr_rsp_n4", {31'd0, rv_log[n0 + 4]}, 32'd1);

        // preload then four back-to-back reads
        push_cmd(1'b1, 1'b1, 4'h2, 16'hA1B2, 17'h0, n0);
        push_cmd(1'b1, 1'b1, 4'h4, 16'hC3D4, 17'h0, n0);
        push_cmd(1'b1, 1'b1, 4'h6, 16'h1234, 17'h0, n0);
        push_cmd(1'b1, 1'b1, 4'h8, 16'h5678, 17'h0, n0);
        cmd_valid = 1'b0;
        wait_idle();
        push_cmd(1'b0, 1'b1, 4'h2, 16'h0, {1'b0, 16'hA1B2}, n0);
        push_cmd(1'b0, 1'b1, 4'h4, 16'h0, {1'b0, 16'hC3D4}, n1);
        push_cmd(1'b0, 1'b0, 4'h6, 16'h0, {1'b0, 16'h0034}, n1);
        push_cmd(1'b0, 1'b1, 4'h8, 16'h0, {1'b0, 16'h5678}, n1);
        cmd_valid = 1'b0;
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            check_bus("b2b", n0 + 2 + i, 2'b10, 4'(2 + 2 * i));
            check("b2b_rsp", {31'd0, rv_log[n0 + 4 + i]}, 32'd1);
        end

        // error on read-only register retracts the following address phase
        push_cmd(1'b1, 1'b1, 4'h0, 16'hFFFF, {1'b1, 16'h0000}, n0);
        push_cmd(1'b1, 1'b1, 4'h6, 16'h0101, 17'h0, n1);
        cmd_valid = 1'b0;
        wait_idle();
        check_bus("err_first", n0 + 2, 2'b10, 4'h0);
        check_bus("err_presented", n0 + 3, 2'b10, 4'h6);
        check_bus("err_idle", n0 + 4, 2'b00, 4'h0);
        check("err_idle_hsel", {31'd0, sel_log[n0 + 4]}, 32'd0);
        check_bus("err_retry", n0 + 5, 2'b10, 4'h6);
        check("err_rsp1", {31'd0, rv_log[n0 + 4]}, 32'd1);
        check("err_rsp2", {31'd0, rv_log[n0 + 7]}, 32'd1);
        push_cmd(1'b0, 1'b1, 4'h6, 16'h0, {1'b0, 16'h0101}, n2);
        cmd_valid = 1'b0;
        wait_idle();

        // two wait states in a write data phase with a second command queued
        push_cmd(1'b1, 1'b1, 4'h8, 16'hCAFE, 17'h0, n0);
        push_cmd(1'b1, 1'b1, 4'h4, 16'h1111, 17'h0, n1);
        cmd_valid = 1'b0;
        wait_until(n0 + 3);
        hready = 1'b0;
        wait_until(n0 + 5);
        hready = 1'b1;
        wait_idle();
        for (int c = 3; c <= 5; c++) begin
            check("ws_hwdata", {16'd0, wd_log[n0 + c]}, 32'h0000CAFE);
            check_bus("ws_hold", n0 + c, 2'b10, 4'h4);
        end
        check("ws_rsp_n5", {31'd0, rv_log[n0 + 5]}, 32'd0);
        check("ws_rsp_n6", {31'd0, rv_log[n0 + 6]}, 32'd1);
        check("ws_rsp_n7", {31'd0, rv_log[n0 + 7]}, 32'd1);

        // stall from reset: queue plus address slot absorb five commands
        rst = 1'b1; hready = 1'b0; sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        k = 0;
        cmd_write = 1'b0; cmd_wdata = 16'h0; cmd_size = fs[0]; cmd_addr = fa[0]; cmd_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                if (k < 5) sb_q.push_back({1'b0, fe[k]});
                k++;
            end
            @(posedge clk); #1;
            if (k < 6) begin
                cmd_size = fs[k];
                cmd_addr = fa[k];
            end
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        check("full_accepted", k, 32'd5);
        check("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        hready = 1'b1;
        @(negedge clk);
        check("full_release_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("full_after_pop_ready", {31'd0, cmd_ready}, 32'd1);
        wait_idle();
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
